rv_ex_mem_stage: RTL and testbench
==================================

Name: rv_ex_mem_stage

Overview:
- Execute-to-memory pipeline stage; sits directly downstream of the integer ALU.
- Registers the ALU result, zero flag and execute-stage control into the memory stage.
- Resolves branches and jumps: B-type ALU compare yields result 1 when the condition holds, so taken = branch & !zero.
- Issues a one-cycle PC redirect, then squashes a fixed number of wrong-path instructions still arriving from execute.

Parameters:
- XLEN, 32, datapath width.
- KILL_SLOTS, 2, wrong-path instructions dropped after a redirect (1..7).

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous reset, active-high
- i_ex_valid  in  1  execute-stage instruction valid
- o_ex_ready  out  1  stage can accept
- i_alu_result  in  XLEN  ALU result
- i_alu_zero  in  1  ALU zero flag
- i_pc  in  XLEN  instruction PC
- i_imm  in  XLEN  sign-extended immediate
- i_rs1  in  XLEN  rs1 value (JALR base)
- i_rs2  in  XLEN  store data
- i_rd  in  5  destination register
- i_funct3  in  3  memory access size/sign
- i_is_branch, i_is_jal, i_is_jalr, i_mem_rd, i_mem_wr, i_reg_wr  in  1 each  decoded control
- o_mem_valid  out  1  memory-stage instruction valid
- i_mem_ready  in  1  memory stage accepts
- o_mem_addr  out  XLEN  registered ALU result (address or writeback value)
- o_mem_wdata  out  XLEN  registered rs2
- o_mem_rd  out  5;  o_mem_funct3  out  3;  o_mem_mem_rd, o_mem_mem_wr, o_mem_reg_wr  out  1 each
- o_redirect  out  1  one-cycle PC redirect pulse
- o_redirect_pc  out  XLEN  redirect target
- o_fwd_valid  out  1  held instruction writes rd != 0
- o_fwd_rd  out  5;  o_fwd_data  out  XLEN  forwarding to execute
- o_trap  out  1  misaligned target (optional feature only; tied 0 otherwise)

Behaviour:
- Reset, asynchronous: o_mem_valid=0, o_redirect=0, o_trap=0, kill counter=0, all data registers 0, state RUN.
- o_ex_ready = !o_mem_valid | i_mem_ready (combinational). An instruction transfers when i_ex_valid & o_ex_ready.
- Latency: 1 cycle from transfer to o_mem_valid. Registers hold while o_mem_valid & !i_mem_ready. o_mem_valid clears when the held entry is consumed and nothing new transfers.
- Targets:
  - branch/JAL: i_pc + i_imm
  - JALR: (i_rs1 + i_imm) & ~1
  - All additions wrap modulo 2^XLEN.
- Link value: for JAL/JALR, o_mem_addr = i_pc + 4, replacing i_alu_result.
- Taken = i_is_jal | i_is_jalr | (i_is_branch & !i_alu_zero).
- State machine RUN / KILL:
  - RUN: a taken transfer pulses o_redirect for exactly the next cycle with o_redirect_pc; loads counter=KILL_SLOTS; state -> KILL. The taken instruction itself proceeds to memory (link writeback).
  - KILL: o_ex_ready follows the RUN rule; accepted instructions are discarded (not loaded, no redirect); counter decrements per discard; counter reaches 0 -> RUN. Taken instructions in KILL are ignored.
- Boundary cases:
  - Redirect in the same cycle as a memory-stage stall: the pulse is still single-cycle; the held entry is unaffected.
  - Reset mid-KILL returns to RUN with counter 0.
  - rd == 0: o_fwd_valid=0.
- Forwarding: o_fwd_valid = o_mem_valid & o_mem_reg_wr & (o_mem_rd != 0); o_fwd_data = o_mem_addr.

Optional Feature:
- Macro RV_MISALIGN_TRAP_EN.
- Defined: on a taken transfer with target[1] == 1:
  - no redirect;
  - o_trap pulses 1 cycle;
  - instruction enters memory with o_mem_reg_wr=0;
  - state -> KILL.
- Undefined: no check; o_trap constant 0.

Decomposition:
- Shared package rv_pkg: XLEN; stage state enum (RUN, KILL); memory-stage bundle struct (addr, wdata, rd, funct3, mem_rd, mem_wr, reg_wr).
- One sub-module, rv_branch_unit: combinational taken/target/link computation. All state stays in the top.

Test Plan:
1. ADD result 0x0000_1234, rd=5, i_mem_ready=1 -> next cycle o_mem_valid=1, o_mem_addr=0x1234, o_fwd_valid=1, o_fwd_rd=5.
2. BEQ at pc 0x100, imm 0x40, alu_zero=0 -> o_redirect pulses one cycle with 0x140; next two valid execute instructions are dropped; the third appears at memory.
3. BNE with alu_zero=1 -> no redirect; the following instruction passes normally.
4. JALR rs1=0x2003, imm=0, pc=0x80 -> redirect 0x2002; o_mem_addr=0x84 (with RV_MISALIGN_TRAP_EN: o_trap=1, no redirect).
5. i_mem_ready=0 for 3 cycles while o_mem_valid=1 -> o_ex_ready=0 and outputs stable; the held entry is released on the ready cycle.
6. Assert i_reset during KILL (counter=1) -> o_mem_valid=0 immediately; after release, the first instruction passes.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared types for the execute-to-memory stage.
//   XLEN         : datapath width
//   stage_state_e: RUN (normal) / KILL (dropping wrong-path instructions)
//   mem_bundle_t : everything the memory stage needs from one instruction
package rv_pkg;
  localparam int XLEN = 32;

  typedef enum logic {ST_RUN, ST_KILL} stage_state_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            mem_rd;
    logic            mem_wr;
    logic            reg_wr;
  } mem_bundle_t;
endpackage

// File: rtl/rv_ex_mem_stage_if.sv
// Bus bundle of the EX/MEM stage.
//   i_* : execute-side request, memory-side ready
//   o_* : memory-stage entry, redirect, forwarding, trap
// master = upstream/environment side, slave = the stage itself.
interface rv_ex_mem_stage_if;
  import rv_pkg::*;

  logic            i_ex_valid;
  logic            o_ex_ready;
  logic [XLEN-1:0] i_alu_result;
  logic            i_alu_zero;
  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic [4:0]      i_rd;
  logic [2:0]      i_funct3;
  logic            i_is_branch, i_is_jal, i_is_jalr;
  logic            i_mem_rd, i_mem_wr, i_reg_wr;

  logic            o_mem_valid;
  logic            i_mem_ready;
  logic [XLEN-1:0] o_mem_addr;
  logic [XLEN-1:0] o_mem_wdata;
  logic [4:0]      o_mem_rd;
  logic [2:0]      o_mem_funct3;
  logic            o_mem_mem_rd, o_mem_mem_wr, o_mem_reg_wr;

  logic            o_redirect;
  logic [XLEN-1:0] o_redirect_pc;
  logic            o_fwd_valid;
  logic [4:0]      o_fwd_rd;
  logic [XLEN-1:0] o_fwd_data;
  logic            o_trap;

  modport master (
    output i_ex_valid, i_alu_result, i_alu_zero, i_pc, i_imm, i_rs1, i_rs2,
           i_rd, i_funct3, i_is_branch, i_is_jal, i_is_jalr,
           i_mem_rd, i_mem_wr, i_reg_wr, i_mem_ready,
    input  o_ex_ready, o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_rd,
           o_mem_funct3, o_mem_mem_rd, o_mem_mem_wr, o_mem_reg_wr,
           o_redirect, o_redirect_pc, o_fwd_valid, o_fwd_rd, o_fwd_data, o_trap
  );

  modport slave (
    input  i_ex_valid, i_alu_result, i_alu_zero, i_pc, i_imm, i_rs1, i_rs2,
           i_rd, i_funct3, i_is_branch, i_is_jal, i_is_jalr,
           i_mem_rd, i_mem_wr, i_reg_wr, i_mem_ready,
    output o_ex_ready, o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_rd,
           o_mem_funct3, o_mem_mem_rd, o_mem_mem_wr, o_mem_reg_wr,
           o_redirect, o_redirect_pc, o_fwd_valid, o_fwd_rd, o_fwd_data, o_trap
  );
endinterface

// File: rtl/rv_branch_unit.sv
// Combinational branch/jump resolution.
//   i_pc/i_imm/i_rs1     : target operands
//   i_alu_result/zero    : ALU outputs (B-type compare gives 1 when condition holds)
//   i_is_branch/jal/jalr : decoded control
//   o_taken, o_target    : control-flow change and its destination
//   o_wb_val             : value carried to memory (link PC+4 for jumps)
module rv_branch_unit
  import rv_pkg::*;
(
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic            i_alu_zero,
  input  logic            i_is_branch,
  input  logic            i_is_jal,
  input  logic            i_is_jalr,
  output logic            o_taken,
  output logic [XLEN-1:0] o_target,
  output logic [XLEN-1:0] o_wb_val
);
  logic [XLEN-1:0] jalr_sum;

  assign jalr_sum = i_rs1 + i_imm;
  // Compare result of 1 means "condition true" -> zero flag low means taken.
  assign o_taken  = i_is_jal | i_is_jalr | (i_is_branch & ~i_alu_zero);
  assign o_target = i_is_jalr ? (jalr_sum & ~XLEN'(1)) : (i_pc + i_imm);
  assign o_wb_val = (i_is_jal | i_is_jalr) ? (i_pc + XLEN'(4)) : i_alu_result;
endmodule

// File: rtl/rv_ex_mem_stage.sv
// Execute-to-memory pipeline register with branch resolution.
//   i_clk, i_reset : clock, async active-high reset
//   bus (slave)    : EX handshake + operands in, MEM entry / redirect /
//                    forwarding / trap out
// After a taken transfer a one-cycle redirect is issued and the next
// KILL_SLOTS accepted instructions (already fetched down the wrong path)
// are discarded.
// Optional: define RV_MISALIGN_TRAP_EN to trap (instead of redirect) on
// taken targets with bit 1 set; without it o_trap stays 0.
module rv_ex_mem_stage
  import rv_pkg::*;
#(
  parameter int KILL_SLOTS = 2
) (
  input logic               i_clk,
  input logic               i_reset,
  rv_ex_mem_stage_if.slave  bus
);
  localparam logic [2:0] KILL_INIT = 3'(KILL_SLOTS);

  stage_state_e    state_q;
  logic [2:0]      cnt_q;
  mem_bundle_t     mem_q, mem_d;
  logic            mem_valid_q;
  logic            redir_q, trap_q;
  logic [XLEN-1:0] redir_pc_q;

  logic            taken, mis, xfer;
  logic [XLEN-1:0] target, wb_val;

  rv_branch_unit u_br (
    .i_pc        (bus.i_pc),
    .i_imm       (bus.i_imm),
    .i_rs1       (bus.i_rs1),
    .i_alu_result(bus.i_alu_result),
    .i_alu_zero  (bus.i_alu_zero),
    .i_is_branch (bus.i_is_branch),
    .i_is_jal    (bus.i_is_jal),
    .i_is_jalr   (bus.i_is_jalr),
    .o_taken     (taken),
    .o_target    (target),
    .o_wb_val    (wb_val)
  );

`ifdef RV_MISALIGN_TRAP_EN
  assign mis = target[1];
`else
  assign mis = 1'b0;
`endif

  assign bus.o_ex_ready = ~mem_valid_q | bus.i_mem_ready;
  assign xfer           = bus.i_ex_valid & bus.o_ex_ready;

  always_comb begin
    mem_d        = '0;
    mem_d.addr   = wb_val;
    mem_d.wdata  = bus.i_rs2;
    mem_d.rd     = bus.i_rd;
    mem_d.funct3 = bus.i_funct3;
    mem_d.mem_rd = bus.i_mem_rd;
    mem_d.mem_wr = bus.i_mem_wr;
    // A trapping jump must not write its link register.
    mem_d.reg_wr = bus.i_reg_wr & ~(taken & mis);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      mem_q       <= '0;
      mem_valid_q <= 1'b0;
      redir_q     <= 1'b0;
      redir_pc_q  <= '0;
      trap_q      <= 1'b0;
    end else begin
      redir_q <= 1'b0;
      trap_q  <= 1'b0;
      // Held entry consumed; a load below overrides this.
      if (bus.i_mem_ready) mem_valid_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (xfer) begin
            mem_q       <= mem_d;
            mem_valid_q <= 1'b1;
            if (taken) begin
              cnt_q   <= KILL_INIT;
              state_q <= ST_KILL;
              if (mis) begin
                trap_q <= 1'b1;
              end else begin
                redir_q    <= 1'b1;
                redir_pc_q <= target;
              end
            end
          end
        end
        ST_KILL: begin
          // Wrong-path instruction: swallow it, taken or not.
          if (xfer) begin
            cnt_q <= cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign bus.o_mem_valid   = mem_valid_q;
  assign bus.o_mem_addr    = mem_q.addr;
  assign bus.o_mem_wdata   = mem_q.wdata;
  assign bus.o_mem_rd      = mem_q.rd;
  assign bus.o_mem_funct3  = mem_q.funct3;
  assign bus.o_mem_mem_rd  = mem_q.mem_rd;
  assign bus.o_mem_mem_wr  = mem_q.mem_wr;
  assign bus.o_mem_reg_wr  = mem_q.reg_wr;
  assign bus.o_redirect    = redir_q;
  assign bus.o_redirect_pc = redir_pc_q;
  assign bus.o_trap        = trap_q;
  assign bus.o_fwd_valid   = mem_valid_q & mem_q.reg_wr & (mem_q.rd != 5'd0);
  assign bus.o_fwd_rd      = mem_q.rd;
  assign bus.o_fwd_data    = mem_q.addr;
endmodule

// File: tb/tb_rv_ex_mem_stage.sv
module tb_rv_ex_mem_stage;
  localparam int KS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv_ex_mem_stage_if bus();
  rv_ex_mem_stage #(.KILL_SLOTS(KS)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: expected memory-stage entry plus "instructions still to drop".
  logic        m_valid, m_redir, m_trap, m_mrd, m_mwr, m_rwr;
  logic [31:0] m_addr, m_wdata, m_rpc;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  int          m_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_valid = 0; m_redir = 0; m_trap = 0; m_mrd = 0; m_mwr = 0; m_rwr = 0;
    m_addr = 0; m_wdata = 0; m_rpc = 0; m_rd = 0; m_f3 = 0; m_drop = 0;
  endtask

  task automatic m_update();
    logic ready, acc, taken, mis;
    logic [31:0] tgt;
    ready = !m_valid || bus.i_mem_ready;
    acc   = bus.i_ex_valid && ready;
    taken = bus.i_is_jal || bus.i_is_jalr || (bus.i_is_branch && !bus.i_alu_zero);
    tgt   = bus.i_is_jalr ? ((bus.i_rs1 + bus.i_imm) & 32'hFFFF_FFFE) : (bus.i_pc + bus.i_imm);
    mis   = 1'b0;
`ifdef RV_MISALIGN_TRAP_EN
    mis   = tgt[1];
`endif
    m_redir = 0; m_trap = 0;
    if (acc && m_drop > 0) begin
      m_drop--;
      if (bus.i_mem_ready) m_valid = 0;
    end else if (acc) begin
      m_valid = 1;
      m_addr  = (bus.i_is_jal || bus.i_is_jalr) ? bus.i_pc + 32'd4 : bus.i_alu_result;
      m_wdata = bus.i_rs2; m_rd = bus.i_rd; m_f3 = bus.i_funct3;
      m_mrd = bus.i_mem_rd; m_mwr = bus.i_mem_wr;
      m_rwr = bus.i_reg_wr && !(taken && mis);
      if (taken) begin
        m_drop = KS;
        if (mis) m_trap = 1;
        else begin m_redir = 1; m_rpc = tgt; end
      end
    end else if (bus.i_mem_ready) m_valid = 0;
  endtask

  task automatic chk_all();
    chk("mem_valid", bus.o_mem_valid, m_valid);
    chk("mem_addr", bus.o_mem_addr, m_addr);
    chk("mem_wdata", bus.o_mem_wdata, m_wdata);
    chk("mem_rd", bus.o_mem_rd, m_rd);
    chk("mem_funct3", bus.o_mem_funct3, m_f3);
    chk("mem_ctl", {bus.o_mem_mem_rd, bus.o_mem_mem_wr, bus.o_mem_reg_wr}, {m_mrd, m_mwr, m_rwr});
    chk("redirect", bus.o_redirect, m_redir);
    if (m_redir) chk("redirect_pc", bus.o_redirect_pc, m_rpc);
    chk("trap", bus.o_trap, m_trap);
    chk("fwd_valid", bus.o_fwd_valid, m_valid && m_rwr && (m_rd != 0));
    chk("fwd_rd", bus.o_fwd_rd, m_rd);
    chk("fwd_data", bus.o_fwd_data, m_addr);
  endtask

  // kind: 0 ALU, 1 branch, 2 JAL, 3 JALR, 4 load, 5 store
  task automatic set_ins(input logic v, input int kind, input logic [31:0] alu, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] rs1, input logic z, input logic [4:0] rd);
    bus.i_ex_valid = v; bus.i_alu_result = alu; bus.i_alu_zero = z;
    bus.i_pc = pc; bus.i_imm = imm; bus.i_rs1 = rs1; bus.i_rs2 = alu ^ 32'hA5A5_5A5A;
    bus.i_rd = rd; bus.i_funct3 = pc[4:2];
    bus.i_is_branch = (kind == 1); bus.i_is_jal = (kind == 2); bus.i_is_jalr = (kind == 3);
    bus.i_mem_rd = (kind == 4); bus.i_mem_wr = (kind == 5);
    bus.i_reg_wr = !(kind == 1 || kind == 5);
  endtask

  // Check combinational ready, advance model, clock, check registered outputs.
  task automatic step();
    #1;
    chk("ex_ready", bus.o_ex_ready, !m_valid || bus.i_mem_ready);
    m_update();
    @(posedge clk);
    @(negedge clk);
    chk_all();
  endtask

  initial begin
    rst = 1'b1;
    bus.i_mem_ready = 1'b1;
    set_ins(0, 0, 0, 0, 0, 0, 0, 0);
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", bus.o_mem_valid, 0);
    chk("rst_redirect", bus.o_redirect, 0);
    chk("rst_trap", bus.o_trap, 0);
    chk("rst_addr", bus.o_mem_addr, 0);
    chk("rst_fwd", bus.o_fwd_valid, 0);
    rst = 1'b0;

    // 1: plain ALU op
    set_ins(1, 0, 32'h1234, 32'h10, 0, 0, 0, 5'd5); step();
    chk("t1_valid", bus.o_mem_valid, 1);
    chk("t1_addr", bus.o_mem_addr, 32'h1234);
    chk("t1_fwd_valid", bus.o_fwd_valid, 1);
    chk("t1_fwd_rd", bus.o_fwd_rd, 5);

    // 2: taken BEQ, two wrong-path drops, third passes
    set_ins(1, 1, 32'h1, 32'h100, 32'h40, 0, 0, 5'd0); step();
    chk("t2_redir", bus.o_redirect, 1);
    chk("t2_rpc", bus.o_redirect_pc, 32'h140);
    set_ins(1, 0, 32'hAAA1, 32'h104, 0, 0, 0, 5'd7); step();
    chk("t2_pulse", bus.o_redirect, 0);
    chk("t2_drop1", bus.o_mem_valid, 0);
    set_ins(1, 2, 32'hAAA2, 32'h108, 32'h8, 0, 0, 5'd7); step();
    chk("t2_drop2", bus.o_mem_valid, 0);
    chk("t2_drop2_redir", bus.o_redirect, 0);
    set_ins(1, 0, 32'hAAA3, 32'h140, 0, 0, 0, 5'd7); step();
    chk("t2_third", bus.o_mem_valid, 1);
    chk("t2_third_addr", bus.o_mem_addr, 32'hAAA3);

    // 3: not-taken branch (zero set)
    set_ins(1, 1, 32'h0, 32'h200, 32'h20, 0, 1, 5'd0); step();
    chk("t3_noredir", bus.o_redirect, 0);
    set_ins(1, 0, 32'h55, 32'h204, 0, 0, 0, 5'd3); step();
    chk("t3_next", bus.o_mem_addr, 32'h55);

    // 4: JALR to odd base
    set_ins(1, 3, 32'hDEAD, 32'h80, 0, 32'h2003, 0, 5'd1); step();
    chk("t4_link", bus.o_mem_addr, 32'h84);
`ifdef RV_MISALIGN_TRAP_EN
    chk("t4_trap", bus.o_trap, 1);
    chk("t4_noredir", bus.o_redirect, 0);
    chk("t4_nowr", bus.o_mem_reg_wr, 0);
`else
    chk("t4_redir", bus.o_redirect, 1);
    chk("t4_rpc", bus.o_redirect_pc, 32'h2002);
`endif
    set_ins(1, 0, 32'h11, 32'h84, 0, 0, 0, 5'd2); step();
    set_ins(1, 0, 32'h22, 32'h88, 0, 0, 0, 5'd2); step();
    chk("t4_drained", bus.o_mem_valid, 0);

    // 5: memory-stage stall
    set_ins(1, 0, 32'h777, 32'h300, 0, 0, 0, 5'd9); step();
    set_ins(1, 0, 32'h888, 32'h304, 0, 0, 0, 5'd10);
    bus.i_mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_hold", bus.o_mem_addr, 32'h777);
      chk("t5_ready", bus.o_ex_ready, 0);
    end
    bus.i_mem_ready = 1'b1; step();
    chk("t5_next", bus.o_mem_addr, 32'h888);

    // 6: reset during KILL with one slot left
    set_ins(1, 2, 32'h0, 32'h400, 32'h10, 0, 0, 5'd1); step();
    set_ins(1, 0, 32'h333, 32'h404, 0, 0, 0, 5'd4); step();
    #2 rst = 1'b1;
    #1;
    m_reset();
    chk("t6_valid", bus.o_mem_valid, 0);
    chk("t6_addr", bus.o_mem_addr, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    set_ins(1, 0, 32'h999, 32'h500, 0, 0, 0, 5'd4); step();
    chk("t6_pass", bus.o_mem_valid, 1);
    chk("t6_pass_addr", bus.o_mem_addr, 32'h999);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      set_ins($urandom_range(0, 4) != 0, int'($urandom_range(0, 5)), $urandom,
              $urandom & 32'hFFFF_FFFC, $urandom_range(0, 255) << 1, $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      bus.i_mem_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
